switch_input_ctrl: RTL and testbench
====================================

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

Interface
REQ-001 Parameter TICK_MAX, default 100000, gives the sample-tick period in clk cycles (1 ms at 100 MHz).
REQ-002 Parameter STABLE_N, default 4, is the number of consecutive differing samples required to commit a change.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic SHALL be posedge clk.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sw_raw, input, 16 bits: asynchronous board switches.
REQ-006 Port btn_raw, input, 1 bit: asynchronous confirm button.
REQ-007 Port IORead, input, 1 bit: CPU I/O read strobe.
REQ-008 Port io_sel, input, 1 bit: read selection; 0 = latched switches, 1 = status.
REQ-009 Port io_read_data, output, 16 bits: registered CPU read data, which also feeds the display path.
REQ-010 Port sw_live, output, 16 bits: current debounced switch vector.
REQ-011 Port data_ready, output, 1 bit: latched value not yet read.
REQ-012 Port confirm_pulse, output, 1 bit: one-cycle confirm event.

Function
REQ-013 Each of the 17 raw inputs SHALL pass a 2-flop synchronizer before any other use.
REQ-014 The tick counter SHALL count 0..TICK_MAX-1 and then wrap to 0.
- tick is high for exactly one cycle, on the cycle the count equals TICK_MAX-1.
REQ-015 Each input SHALL have a per-bit debounce counter, updated on tick cycles only.
- Synchronized bit equals its stable bit: counter clears.
- Bits differ and counter < STABLE_N-1: counter increments.
- Bits differ and counter == STABLE_N-1: stable bit takes the synchronized value and counter clears.
REQ-016 Commit latency from a raw edge SHALL lie within (STABLE_N-1)*TICK_MAX+3 .. STABLE_N*TICK_MAX+3 cycles.
REQ-017 A raw glitch shorter than (STABLE_N-1)*TICK_MAX cycles SHALL never change the stable value.
REQ-018 sw_live SHALL equal the 16 stable switch bits.
REQ-019 confirm_pulse SHALL be high for one cycle, in the cycle after the stable button bit rises 0->1.
- It SHALL not fire on the falling transition.
REQ-020 In the confirm_pulse cycle, sw_live SHALL be captured into sw_latched, and data_ready SHALL be 1 from the next cycle.
REQ-021 IORead=1 with io_sel=0 SHALL load io_read_data with sw_latched, visible next cycle.
- The same read SHALL clear data_ready next cycle.
REQ-022 IORead=1 with io_sel=1 SHALL load io_read_data with {15'b0, data_ready}, visible next cycle.
- This read SHALL NOT clear data_ready.
REQ-023 When IORead=0, io_read_data SHALL hold its last value.
REQ-024 Simultaneous confirm_pulse and a switch read: the set wins.
- data_ready ends at 1.
- sw_latched takes the new value.
- io_read_data returns the pre-capture sw_latched.
REQ-025 A confirm while data_ready=1 SHALL overwrite sw_latched; there is no overflow flag.
REQ-026 Switch changes after capture SHALL NOT alter sw_latched until the next confirm.

Reset
REQ-027 While rst=1 at a clk edge, the following SHALL all load 0:
- synchronizer flops
- tick counter
- debounce counters
- stable bits
- sw_latched
- data_ready
- io_read_data
- confirm_pulse
REQ-028 Reset mid-debounce SHALL discard partial counts; a raw level held through reset is re-debounced from zero.
REQ-029 A raw button held high through reset release SHALL produce exactly one confirm_pulse after debounce.

Structure
REQ-030 A shared package io_pkg SHALL hold the following constants:
- TICK_MAX_DEF
- STABLE_N_DEF
- IO_SEL_SW = 1'b0
- IO_SEL_STAT = 1'b1
REQ-031 One sub-module, debounce_bit, SHALL contain the synchronizer, debounce counter and stable flop for one input.
- It is instantiated 17 times and shares the parent's tick.
REQ-032 The counter width SHALL be $clog2(STABLE_N); the tick counter width SHALL be $clog2(TICK_MAX).

Verification (TICK_MAX=4, STABLE_N=3)
REQ-033 Reset, then idle for 20 cycles -> io_read_data=0, sw_live=0, data_ready=0, confirm_pulse never high.
REQ-034 sw_raw=16'hA5C3 held -> sw_live=16'hA5C3 within 11..15 cycles and not before.
REQ-035 With sw_live=16'hA5C3, pulse sw_raw to 16'hFFFF for 3 cycles -> sw_live stays 16'hA5C3 throughout.
REQ-036 With sw_live=16'h00F0, hold btn_raw=1 -> exactly one confirm_pulse and data_ready=1. Then:
- Read with io_sel=1 returns 16'h0001.
- Read with io_sel=0 returns 16'h00F0, and data_ready=0 one cycle later.
REQ-037 Set sw_raw=16'h1234, confirm, then set sw_raw=16'h5678 with no confirm -> a switch read returns 16'h1234 while sw_live=16'h5678.
REQ-038 Align a switch read with the confirm_pulse cycle (old latched 16'h1111, new 16'h2222):
- The read returns 16'h1111.
- data_ready stays 1.
- The next read returns 16'h2222.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the switch input controller
package io_pkg;

  localparam int   TICK_MAX_DEF = 100000;
  localparam int   STABLE_N_DEF = 4;
  localparam logic IO_SEL_SW    = 1'b0;
  localparam logic IO_SEL_STAT  = 1'b1;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchronizer, debounce counter and stable flop for one raw input
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_N = STABLE_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int            CW       = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Only tick-spaced samples count, so a glitch must outlast several ticks to commit.
      if (tick) begin
        if (sync2 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_input_ctrl.sv
// rtl/switch_input_ctrl.sv - debounced switch bank with button-confirmed capture and CPU read port
module switch_input_ctrl
  import io_pkg::*;
#(
  parameter int TICK_MAX = TICK_MAX_DEF,
  parameter int STABLE_N = STABLE_N_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_raw,
  input  logic        btn_raw,
  input  logic        IORead,
  input  logic        io_sel,
  output logic [15:0] io_read_data,
  output logic [15:0] sw_live,
  output logic        data_ready,
  output logic        confirm_pulse
);

  localparam int            TW        = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [16:0]   raw_all;
  logic [16:0]   stable_all;
  logic          btn_stable;
  logic          btn_prev;
  logic [15:0]   sw_latched;

  assign tick    = (tick_cnt == TICK_LAST);
  assign raw_all = {btn_raw, sw_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Bits 0..15 are the switches, bit 16 is the confirm button.
  for (genvar i = 0; i < 17; i++) begin : g_db
    debounce_bit #(
      .STABLE_N (STABLE_N)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .raw    (raw_all[i]),
      .stable (stable_all[i])
    );
  end

  assign sw_live    = stable_all[15:0];
  assign btn_stable = stable_all[16];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev      <= 1'b0;
      confirm_pulse <= 1'b0;
      sw_latched    <= '0;
      data_ready    <= 1'b0;
      io_read_data  <= '0;
    end else begin
      btn_prev      <= btn_stable;
      confirm_pulse <= btn_stable & ~btn_prev;
      // A capture takes priority over a simultaneous switch read clearing the flag.
      if (confirm_pulse) begin
        sw_latched <= sw_live;
        data_ready <= 1'b1;
      end else if (IORead && (io_sel == IO_SEL_SW)) begin
        data_ready <= 1'b0;
      end
      if (IORead) begin
        io_read_data <= (io_sel == IO_SEL_STAT) ? {15'b0, data_ready} : sw_latched;
      end
    end
  end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// tb/tb_switch_input_ctrl.sv - randomized and directed bench with behavioural model for switch_input_ctrl
module tb_switch_input_ctrl;

  localparam int TM = 4;
  localparam int SN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic        btn_raw = 1'b0;
  logic        IORead = 1'b0;
  logic        io_sel = 1'b0;
  logic [15:0] io_read_data;
  logic [15:0] sw_live;
  logic        data_ready;
  logic        confirm_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  switch_input_ctrl #(
    .TICK_MAX (TM),
    .STABLE_N (SN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_raw        (sw_raw),
    .btn_raw       (btn_raw),
    .IORead        (IORead),
    .io_sel        (io_sel),
    .io_read_data  (io_read_data),
    .sw_live       (sw_live),
    .data_ready    (data_ready),
    .confirm_pulse (confirm_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw inputs reach the debouncer two samples late; a bit commits once
  // SN consecutive tick samples disagree with its stable value.
  bit          m_valid = 1'b0;
  logic [16:0] hist[$];
  logic [16:0] m_stable;
  int          m_run[17];
  int          m_edges;
  logic        m_rose, m_pulse, m_dr;
  logic [15:0] m_latched, m_rd;

  always @(posedge clk) begin : p_model
    logic [16:0] samp;
    logic [16:0] stable_old;
    logic        pulse_old, dr_old;
    logic [15:0] lat_old;
    if (rst) begin
      m_valid = 1'b1;
      hist.delete();
      m_stable = '0;
      for (int b = 0; b < 17; b++) m_run[b] = 0;
      m_edges = 0;
      m_rose = 1'b0; m_pulse = 1'b0; m_dr = 1'b0;
      m_latched = '0; m_rd = '0;
    end else begin
      samp       = (hist.size() >= 2) ? hist[1] : 17'b0;
      stable_old = m_stable;
      pulse_old  = m_pulse;
      dr_old     = m_dr;
      lat_old    = m_latched;
      if ((m_edges % TM) == TM - 1) begin
        for (int b = 0; b < 17; b++) begin
          if (samp[b] != stable_old[b]) begin
            m_run[b]++;
            if (m_run[b] == SN) begin
              m_stable[b] = samp[b];
              m_run[b] = 0;
            end
          end else begin
            m_run[b] = 0;
          end
        end
      end
      m_pulse = m_rose;
      m_rose  = !stable_old[16] && m_stable[16];
      if (pulse_old) begin
        m_latched = stable_old[15:0];
        m_dr = 1'b1;
      end else if (IORead && !io_sel) begin
        m_dr = 1'b0;
      end
      if (IORead) m_rd = io_sel ? {15'b0, dr_old} : lat_old;
      hist.push_front({btn_raw, sw_raw});
      if (hist.size() > 2) void'(hist.pop_back());
      m_edges++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sw_live", sw_live, m_stable[15:0]);
      chk("model_io_read_data", io_read_data, m_rd);
      chk("model_data_ready", {15'b0, data_ready}, {15'b0, m_dr});
      chk("model_confirm_pulse", {15'b0, confirm_pulse}, {15'b0, m_pulse});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_live(input logic [15:0] v, input string nm);
    int k = 0;
    while (sw_live !== v && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(nm, sw_live, v);
  endtask

  task automatic press(input string nm);
    int k = 0;
    btn_raw = 1'b1;
    while (confirm_pulse !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {15'b0, confirm_pulse}, 16'd1);
    btn_raw = 1'b0;
    step(20);
  endtask

  task automatic cpu_read(input logic sel);
    IORead = 1'b1;
    io_sel = sel;
    @(negedge clk);
    IORead = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, first, bad, k;

    step(3);
    rst = 1'b0;

    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (confirm_pulse) pulses++;
    end
    chk("idle_rd", io_read_data, 16'h0000);
    chk("idle_live", sw_live, 16'h0000);
    chk("idle_dr", {15'b0, data_ready}, 16'd0);
    chk("idle_pulses", 16'(pulses), 16'd0);

    sw_raw = 16'hA5C3;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first < 0 && sw_live == 16'hA5C3) first = i;
    end
    chk("latency_min", {15'b0, first >= 11}, 16'd1);
    chk("latency_max", {15'b0, (first >= 0) && (first <= 15)}, 16'd1);

    sw_raw = 16'hFFFF;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) sw_raw = 16'hA5C3;
      @(negedge clk);
      if (sw_live !== 16'hA5C3) bad++;
    end
    chk("glitch_cycles_changed", 16'(bad), 16'd0);

    sw_raw = 16'h00F0;
    wait_live(16'h00F0, "live_00f0");
    btn_raw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (confirm_pulse) pulses++;
    end
    chk("hold_pulses", 16'(pulses), 16'd1);
    chk("hold_dr", {15'b0, data_ready}, 16'd1);
    cpu_read(1'b1);
    chk("stat_read", io_read_data, 16'h0001);
    chk("stat_keeps_dr", {15'b0, data_ready}, 16'd1);
    cpu_read(1'b0);
    chk("sw_read_00f0", io_read_data, 16'h00F0);
    chk("sw_read_clears_dr", {15'b0, data_ready}, 16'd0);
    btn_raw = 1'b0;
    step(20);

    sw_raw = 16'h1234;
    wait_live(16'h1234, "live_1234");
    press("confirm_1234");
    sw_raw = 16'h5678;
    wait_live(16'h5678, "live_5678");
    cpu_read(1'b0);
    chk("latched_1234", io_read_data, 16'h1234);
    chk("live_still_5678", sw_live, 16'h5678);

    sw_raw = 16'h1111;
    wait_live(16'h1111, "live_1111");
    press("confirm_1111");
    sw_raw = 16'h2222;
    wait_live(16'h2222, "live_2222");
    btn_raw = 1'b1;
    k = 0;
    while (confirm_pulse !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("aligned_pulse_seen", {15'b0, confirm_pulse}, 16'd1);
    cpu_read(1'b0);
    chk("aligned_read_old", io_read_data, 16'h1111);
    chk("aligned_dr_set", {15'b0, data_ready}, 16'd1);
    cpu_read(1'b0);
    chk("next_read_new", io_read_data, 16'h2222);
    btn_raw = 1'b0;
    step(20);

    btn_raw = 1'b1;
    sw_raw = 16'hBEEF;
    step(7);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("reset_live", sw_live, 16'h0000);
    chk("reset_rd", io_read_data, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (confirm_pulse) pulses++;
    end
    chk("held_btn_one_pulse", 16'(pulses), 16'd1);
    chk("redebounced_live", sw_live, 16'hBEEF);
    btn_raw = 1'b0;
    step(20);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) sw_raw = 16'($urandom);
      else if ($urandom_range(0, 3) == 0) sw_raw[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) btn_raw = ~btn_raw;
      IORead = ($urandom_range(0, 2) == 0);
      io_sel = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst = 1'b0;
    IORead = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
